// File: rtl/xsizer_beat_seq_if.sv
// Bus bundle for the sequencing downsizer.
// Upstream wide request/response plus downstream narrow beat port.
interface xsizer_beat_seq_if #(
    parameter int AW  = 19,
    parameter int DWI = 64,
    parameter int DWO = 32
);
    logic               up_vld_i;
    logic               up_rdy_o;
    logic               up_we_i;
    logic [AW-1:0]      up_adr_i;
    logic [DWI-1:0]     up_dat_i;
    logic [DWI/8-1:0]   up_strb_i;
    logic               up_rsp_vld_o;
    logic               up_rsp_rdy_i;
    logic [DWI-1:0]     up_rsp_dat_o;
    logic               dn_vld_o;
    logic               dn_rdy_i;
    logic               dn_we_o;
    logic [AW-1:0]      dn_adr_o;
    logic [DWO-1:0]     dn_dat_o;
    logic [DWO/8-1:0]   dn_strb_o;
    logic               dn_rsp_vld_i;
    logic [DWO-1:0]     dn_rsp_dat_i;

    modport slave (
        input  up_vld_i, up_we_i, up_adr_i, up_dat_i, up_strb_i,
        input  up_rsp_rdy_i, dn_rdy_i, dn_rsp_vld_i, dn_rsp_dat_i,
        output up_rdy_o, up_rsp_vld_o, up_rsp_dat_o,
        output dn_vld_o, dn_we_o, dn_adr_o, dn_dat_o, dn_strb_o
    );

    modport master (
        output up_vld_i, up_we_i, up_adr_i, up_dat_i, up_strb_i,
        output up_rsp_rdy_i, dn_rdy_i, dn_rsp_vld_i, dn_rsp_dat_i,
        input  up_rdy_o, up_rsp_vld_o, up_rsp_dat_o,
        input  dn_vld_o, dn_we_o, dn_adr_o, dn_dat_o, dn_strb_o
    );
endinterface

// File: rtl/xsizer_beat_seq.sv
// Sequencing downsizer: one wide request becomes a run of narrow beats.
// Zero-strobe lanes are skipped; read lanes are reassembled in order.
module xsizer_beat_seq #(
    parameter int AW  = 19,
    parameter int DWI = 64,
    parameter int DWO = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    xsizer_beat_seq_if.slave  bus,
    output logic              busy_o
);
    localparam int R   = DWI / DWO;
    localparam int LR  = $clog2(R);
    localparam int SI  = DWI / 8;
    localparam int SO  = DWO / 8;
    localparam int OFF = $clog2(SI);
    localparam int LO  = $clog2(SO);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        RESP
    } state_t;

    state_t            state;
    logic              we_q;
    logic [AW-OFF-1:0] base_q;
    logic [DWI-1:0]    dat_q;
    logic [SI-1:0]     strb_q;
    logic [R-1:0]      pend;
    logic [R-1:0]      rsp_pend;
    logic [DWI-1:0]    rbuf;

    logic [R-1:0]      cap_pend;
    logic [LR-1:0]     k;
    logic [LR-1:0]     j;
    logic [R-1:0]      pend_clr;
    logic [R-1:0]      rsp_clr;
    logic [R-1:0]      rsp_left;
    logic              rsp_hit;
    logic              unused_adr;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [LR-1:0] low_idx(input logic [R-1:0] v);
        logic [LR-1:0] r;
        r = '0;
        for (int i = R - 1; i >= 0; i--) begin
            if (v[i]) r = LR'(i);
        end
        return r;
    endfunction

    // Per-lane "any byte enabled" mask for the incoming request.
    always_comb begin
        cap_pend = '0;
        for (int l = 0; l < R; l++) begin
            cap_pend[l] = |bus.up_strb_i[l*SO +: SO];
        end
    end

    // Current issue lane, collection lane and their cleared masks.
    always_comb begin
        k        = low_idx(pend);
        j        = low_idx(rsp_pend);
        pend_clr = pend & ~(R'(1) << k);
        rsp_clr  = rsp_pend & ~(R'(1) << j);
        rsp_hit  = bus.dn_rsp_vld_i && (|rsp_pend)
                && (state == ISSUE || state == WAIT_RSP);
        rsp_left = rsp_hit ? rsp_clr : rsp_pend;
    end

    // Control FSM plus captured request and response buffer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            base_q   <= '0;
            dat_q    <= '0;
            strb_q   <= '0;
            pend     <= '0;
            rsp_pend <= '0;
            rbuf     <= '0;
        end else begin
            if (rsp_hit) begin
                rbuf[j*DWO +: DWO] <= bus.dn_rsp_dat_i;
                rsp_pend           <= rsp_clr;
            end
            unique case (state)
                IDLE: begin
                    if (bus.up_vld_i) begin
                        we_q     <= bus.up_we_i;
                        base_q   <= bus.up_adr_i[AW-1:OFF];
                        dat_q    <= bus.up_dat_i;
                        strb_q   <= bus.up_strb_i;
                        pend     <= cap_pend;
                        rsp_pend <= bus.up_we_i ? '0 : cap_pend;
                        rbuf     <= '0;
                        if (|cap_pend)
                            state <= ISSUE;
                        else if (bus.up_we_i)
                            state <= IDLE;
                        else
                            state <= RESP;
                    end
                end
                ISSUE: begin
                    if (bus.dn_rdy_i) begin
                        pend <= pend_clr;
                        if (pend_clr == '0) begin
                            if (we_q)
                                state <= IDLE;
                            else if (|rsp_left)
                                state <= WAIT_RSP;
                            else
                                state <= RESP;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (rsp_left == '0) state <= RESP;
                end
                RESP: begin
                    if (bus.up_rsp_rdy_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.up_rdy_o     = (state == IDLE);
    assign bus.up_rsp_vld_o = (state == RESP);
    assign bus.up_rsp_dat_o = rbuf;
    assign bus.dn_vld_o     = (state == ISSUE);
    assign bus.dn_we_o      = we_q;
    assign bus.dn_adr_o     = {base_q, k, LO'(0)};
    assign bus.dn_dat_o     = dat_q[k*DWO +: DWO];
    assign bus.dn_strb_o    = strb_q[k*SO +: SO];
    assign busy_o           = (state != IDLE);

    assign unused_adr = ^bus.up_adr_i[OFF-1:0];
endmodule

// File: tb/tb_xsizer_beat_seq.sv
// Directed vector bench for the sequencing downsizer.
// Per-cycle table plus a hand-written reset-abort sequence.
module tb_xsizer_beat_seq;
    localparam int AW  = 19;
    localparam int DWI = 64;
    localparam int DWO = 32;

    logic clk;
    logic rst_n;
    logic busy;
    int   checks;
    int   errors;

    xsizer_beat_seq_if #(.AW(AW), .DWI(DWI), .DWO(DWO)) bif ();

    xsizer_beat_seq #(.AW(AW), .DWI(DWI), .DWO(DWO)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bif),
        .busy_o (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic        we;
        logic [18:0] adr;
        logic [63:0] dat;
        logic [7:0]  strb;
        logic        dr;
        logic        rv;
        logic [31:0] rd;
        logic        rr;
    } in_t;

    typedef struct {
        logic        urdy;
        logic        dvld;
        logic        busy;
        logic        rvld;
        logic        we;
        logic [18:0] adr;
        logic [31:0] dat;
        logic [3:0]  strb;
        logic [63:0] rdat;
    } ex_t;

    typedef struct {
        in_t i;
        ex_t e;
    } vec_t;

    function automatic in_t fi(
        input logic vld, input logic we, input logic [18:0] adr,
        input logic [63:0] dat, input logic [7:0] strb,
        input logic dr, input logic rv, input logic [31:0] rd,
        input logic rr);
        in_t r;
        r.vld = vld; r.we = we; r.adr = adr; r.dat = dat;
        r.strb = strb; r.dr = dr; r.rv = rv; r.rd = rd; r.rr = rr;
        return r;
    endfunction

    function automatic ex_t fe(
        input logic urdy, input logic dvld, input logic bz,
        input logic rvld, input logic we, input logic [18:0] adr,
        input logic [31:0] dat, input logic [3:0] strb,
        input logic [63:0] rdat);
        ex_t r;
        r.urdy = urdy; r.dvld = dvld; r.busy = bz; r.rvld = rvld;
        r.we = we; r.adr = adr; r.dat = dat; r.strb = strb;
        r.rdat = rdat;
        return r;
    endfunction

    function automatic vec_t mk(input in_t i, input ex_t e);
        vec_t v;
        v.i = i;
        v.e = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input in_t i);
        bif.up_vld_i     = i.vld;
        bif.up_we_i      = i.we;
        bif.up_adr_i     = i.adr;
        bif.up_dat_i     = i.dat;
        bif.up_strb_i    = i.strb;
        bif.dn_rdy_i     = i.dr;
        bif.dn_rsp_vld_i = i.rv;
        bif.dn_rsp_dat_i = i.rd;
        bif.up_rsp_rdy_i = i.rr;
    endtask

    task automatic compare(input string p, input ex_t e);
        chk({p, ".up_rdy"}, 64'(bif.up_rdy_o), 64'(e.urdy));
        chk({p, ".dn_vld"}, 64'(bif.dn_vld_o), 64'(e.dvld));
        chk({p, ".busy"}, 64'(busy), 64'(e.busy));
        chk({p, ".rsp_vld"}, 64'(bif.up_rsp_vld_o), 64'(e.rvld));
        if (e.dvld) begin
            chk({p, ".dn_we"}, 64'(bif.dn_we_o), 64'(e.we));
            chk({p, ".dn_adr"}, 64'(bif.dn_adr_o), 64'(e.adr));
            chk({p, ".dn_dat"}, 64'(bif.dn_dat_o), 64'(e.dat));
            chk({p, ".dn_strb"}, 64'(bif.dn_strb_o), 64'(e.strb));
        end
        if (e.rvld) begin
            chk({p, ".rsp_dat"}, bif.up_rsp_dat_o, e.rdat);
        end
    endtask

    vec_t vq[$];
    in_t  I;
    ex_t  EI;
    ex_t  EB;

    initial begin
        checks = 0;
        errors = 0;
        I  = fi(0, 0, 0, 0, 0, 1, 0, 0, 0);
        EI = fe(1, 0, 0, 0, 0, 0, 0, 0, 0);
        EB = fe(0, 0, 1, 0, 0, 0, 0, 0, 0);

        // full write
        vq.push_back(mk(fi(1, 1, 'h100, 64'h1122334455667788, 8'hFF, 1, 0, 0, 0), EI));
        vq.push_back(mk(I, fe(0, 1, 1, 0, 1, 'h100, 32'h55667788, 4'hF, 0)));
        vq.push_back(mk(I, fe(0, 1, 1, 0, 1, 'h104, 32'h11223344, 4'hF, 0)));
        // sparse write, upper lane only
        vq.push_back(mk(fi(1, 1, 'h10C, 64'hDEADBEEF01234567, 8'hF0, 1, 0, 0, 0), EI));
        vq.push_back(mk(I, fe(0, 1, 1, 0, 1, 'h10C, 32'hDEADBEEF, 4'hF, 0)));
        // zero-strobe write
        vq.push_back(mk(fi(1, 1, 'h200, 64'h0123456789ABCDEF, 8'h00, 1, 0, 0, 0), EI));
        // full read, first response during issue
        vq.push_back(mk(fi(1, 0, 'h208, 0, 8'hFF, 1, 0, 0, 0), EI));
        vq.push_back(mk(I, fe(0, 1, 1, 0, 0, 'h208, 0, 4'hF, 0)));
        vq.push_back(mk(fi(0, 0, 0, 0, 0, 1, 1, 32'hAAAA0000, 0),
                        fe(0, 1, 1, 0, 0, 'h20C, 0, 4'hF, 0)));
        vq.push_back(mk(fi(0, 0, 0, 0, 0, 1, 1, 32'hBBBB1111, 0), EB));
        vq.push_back(mk(I, fe(0, 0, 1, 1, 0, 0, 0, 0, 64'hBBBB1111AAAA0000)));
        vq.push_back(mk(I, fe(0, 0, 1, 1, 0, 0, 0, 0, 64'hBBBB1111AAAA0000)));
        vq.push_back(mk(fi(0, 0, 0, 0, 0, 1, 0, 0, 1),
                        fe(0, 0, 1, 1, 0, 0, 0, 0, 64'hBBBB1111AAAA0000)));
        // partial read, low lane
        vq.push_back(mk(fi(1, 0, 'h300, 0, 8'h0F, 1, 0, 0, 0), EI));
        vq.push_back(mk(I, fe(0, 1, 1, 0, 0, 'h300, 0, 4'hF, 0)));
        vq.push_back(mk(fi(0, 0, 0, 0, 0, 1, 1, 32'hCAFEF00D, 0), EB));
        vq.push_back(mk(fi(0, 0, 0, 0, 0, 1, 0, 0, 1),
                        fe(0, 0, 1, 1, 0, 0, 0, 0, 64'h00000000CAFEF00D)));
        // zero-strobe read returns 0 with no beat
        vq.push_back(mk(fi(1, 0, 'h400, 0, 8'h00, 1, 0, 0, 0), EI));
        vq.push_back(mk(fi(0, 0, 0, 0, 0, 1, 0, 0, 1),
                        fe(0, 0, 1, 1, 0, 0, 0, 0, 64'h0)));
        // stray response in idle, then backpressured write
        vq.push_back(mk(fi(1, 1, 'h500, 64'h9999000077776666, 8'h3C, 0, 1, 32'h12345678, 0), EI));
        vq.push_back(mk(fi(0, 0, 0, 0, 0, 0, 0, 0, 0),
                        fe(0, 1, 1, 0, 1, 'h500, 32'h77776666, 4'hC, 0)));
        vq.push_back(mk(fi(0, 0, 0, 0, 0, 0, 0, 0, 0),
                        fe(0, 1, 1, 0, 1, 'h500, 32'h77776666, 4'hC, 0)));
        vq.push_back(mk(fi(0, 0, 0, 0, 0, 0, 0, 0, 0),
                        fe(0, 1, 1, 0, 1, 'h500, 32'h77776666, 4'hC, 0)));
        vq.push_back(mk(I, fe(0, 1, 1, 0, 1, 'h500, 32'h77776666, 4'hC, 0)));
        vq.push_back(mk(I, fe(0, 1, 1, 0, 1, 'h504, 32'h99990000, 4'h3, 0)));
        vq.push_back(mk(I, EI));

        rst_n = 1'b0;
        drive(I);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset.up_rdy", 64'(bif.up_rdy_o), 64'd1);
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.dn_vld", 64'(bif.dn_vld_o), 64'd0);
        chk("reset.rsp_vld", 64'(bif.up_rsp_vld_o), 64'd0);
        chk("reset.rsp_dat", bif.up_rsp_dat_o, 64'd0);

        for (int n = 0; n < vq.size(); n++) begin
            drive(vq[n].i);
            #1;
            compare($sformatf("v%0d", n), vq[n].e);
            @(posedge clk);
            #1;
        end

        // reset asserted after the first read beat handshakes
        drive(fi(1, 0, 'h600, 0, 8'hFF, 1, 0, 0, 0));
        @(posedge clk);
        #1;
        drive(I);
        compare("rr.beat0", fe(0, 1, 1, 0, 0, 'h600, 0, 4'hF, 0));
        @(posedge clk);
        #1;
        compare("rr.beat1", fe(0, 1, 1, 0, 0, 'h604, 0, 4'hF, 0));
        #2;
        rst_n = 1'b0;
        #1;
        compare("rr.inrst", EI);
        chk("rr.dn_adr", 64'(bif.dn_adr_o), 64'd0);
        chk("rr.dn_strb", 64'(bif.dn_strb_o), 64'd0);
        chk("rr.rsp_dat", bif.up_rsp_dat_o, 64'd0);
        @(posedge clk);
        #1;
        compare("rr.hold", EI);
        rst_n = 1'b1;
        drive(fi(1, 1, 'h700, 64'hA5A5A5A55A5A5A5A, 8'hF0, 1, 0, 0, 0));
        @(posedge clk);
        #1;
        drive(I);
        compare("rr.post", fe(0, 1, 1, 0, 1, 'h704, 32'hA5A5A5A5, 4'hF, 0));
        @(posedge clk);
        #1;
        compare("rr.done", EI);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
